// File: rtl/data_ram.sv
// data_ram: word-organised data memory with byte-lane stores and zero-latency loads.
// Define DATA_RAM_BOUNDS_CHECK_EN to flag out-of-range accesses instead of aliasing them.
module data_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oob;
    logic                  unused_bits;

    assign idx         = addr[DEPTH_LOG2+1:2];
    assign unused_bits = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};

`ifdef DATA_RAM_BOUNDS_CHECK_EN
    assign oob = |addr[31:DEPTH_LOG2+2];

    // Only the first offending address is kept; err_o stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o      <= 1'b0;
            err_addr_o <= 32'h0;
        end else if (ce && oob) begin
            err_o <= 1'b1;
            if (!err_o) err_addr_o <= addr;
        end
    end
`else
    assign oob        = 1'b0;
    assign err_o      = 1'b0;
    assign err_addr_o = 32'h0;
`endif

    // Reset deliberately leaves the array untouched.
    always_ff @(posedge clk) begin
        if (!rst && ce && we && !oob)
            for (int n = 0; n < 4; n++)
                if (sel[n]) mem[idx][8*n +: 8] <= data_i[8*n +: 8];
    end

    assign data_o = (!rst && ce && !we && !oob) ? mem[idx] : 32'h0;
endmodule
